// File: rtl/instruction_encoder.sv
// Instruction encoder: packs R/I/J field sets into 32-bit words, buffers them
// in a small FIFO and streams them to instruction memory at sequential word
// addresses.
module instruction_encoder #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       immediate,
    input  logic [25:0]       address,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              fmt_err,
    output logic              busy,
    output logic [15:0]       count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_J = 2'd2;

    logic [31:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    level_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       count_q;
    logic              fmt_err_q;

    logic [31:0] enc_word;
    logic        empty;
    logic        full;
    logic        accept;
    logic        push;
    logic        pop;

    // Pack the selected format; fields it does not use are ignored.
    always_comb begin
        enc_word = 32'h0;
        case (fmt)
            FMT_R:   enc_word = {opcode, rs, rt, rd, shamt, funct};
            FMT_I:   enc_word = {opcode, rs, rt, immediate};
            FMT_J:   enc_word = {opcode, address};
            default: enc_word = 32'h0;
        endcase
    end

    // Handshake and FIFO control decode.
    always_comb begin
        empty    = (level_q == '0);
        full     = (level_q == FULL_LEVEL);
        // A pending load_start blocks input even when it is ignored (busy).
        in_ready = !full && !load_start;
        accept   = in_valid && in_ready;
        // Illegal formats are consumed but never enter the FIFO.
        push     = accept && (fmt != 2'd3);
        pop      = !empty && imem_ready;
    end

    // Memory-side outputs come straight from registered state, no bypass.
    always_comb begin
        imem_we    = !empty;
        imem_addr  = addr_q;
        imem_wdata = mem_q[rd_ptr_q];
        fmt_err    = fmt_err_q;
        busy       = !empty;
        count      = count_q;
    end

    // FIFO storage; contents are don't-care while empty so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enc_word;
        end
    end

    // Pointers, occupancy, write address, retire counter and error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            addr_q    <= '0;
            count_q   <= '0;
            fmt_err_q <= 1'b0;
        end else begin
            fmt_err_q <= accept && (fmt == 2'd3);

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end

            if (push && !pop) begin
                level_q <= level_q + (PTR_W + 1)'(1);
            end else if (pop && !push) begin
                level_q <= level_q - (PTR_W + 1)'(1);
            end

            // pop implies non-empty, so it never collides with a load.
            if (pop) begin
                addr_q <= addr_q + ADDR_W'(1);
            end else if (load_start && empty) begin
                addr_q <= start_addr;
            end

            if (pop && (count_q != 16'hFFFF)) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed self-checking bench for instruction_encoder.
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] immediate;
    logic [25:0] address;
    logic        load_start;
    logic [7:0]  start_addr;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ready;
    logic        fmt_err;
    logic        busy;
    logic [15:0] count;

    int n_cmp = 0;
    int n_err = 0;

    instruction_encoder #(.DEPTH(4), .ADDR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fmt        (fmt),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .funct      (funct),
        .immediate  (immediate),
        .address    (address),
        .load_start (load_start),
        .start_addr (start_addr),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_ready (imem_ready),
        .fmt_err    (fmt_err),
        .busy       (busy),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        fmt        = 2'd0;
        opcode     = '0;
        rs         = '0;
        rt         = '0;
        rd         = '0;
        shamt      = '0;
        funct      = '0;
        immediate  = '0;
        address    = '0;
        load_start = 1'b0;
        start_addr = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic drive_r(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] c, input logic [4:0] sh, input logic [5:0] fn);
        in_valid = 1'b1; fmt = 2'd0;
        opcode = op; rs = a; rt = b; rd = c; shamt = sh; funct = fn;
    endtask

    task automatic drive_i(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                           input logic [15:0] imm);
        in_valid = 1'b1; fmt = 2'd1;
        opcode = op; rs = a; rt = b; immediate = imm;
    endtask

    task automatic drive_j(input logic [5:0] op, input logic [25:0] adr);
        in_valid = 1'b1; fmt = 2'd2;
        opcode = op; address = adr;
    endtask

    initial begin
        idle_inputs();
        imem_ready = 1'b1;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_fmt_err", 32'(fmt_err), 32'd0);

        // R-type encode, one-cycle latency, retire count
        drive_r(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        step();
        in_valid = 1'b0;
        check("r_we", 32'(imem_we), 32'd1);
        check("r_addr", 32'(imem_addr), 32'h00);
        check("r_wdata", imem_wdata, 32'h00221820);
        check("r_count_pre", 32'(count), 32'd0);
        step();
        check("r_count", 32'(count), 32'd1);
        check("r_we_after", 32'(imem_we), 32'd0);

        // I then J back-to-back
        do_reset();
        drive_i(6'h08, 5'd1, 5'd2, 16'h0005);
        step();
        check("i_we", 32'(imem_we), 32'd1);
        check("i_addr", 32'(imem_addr), 32'h00);
        check("i_wdata", imem_wdata, 32'h20220005);
        drive_j(6'h02, 26'h0000010);
        step();
        in_valid = 1'b0;
        check("j_we", 32'(imem_we), 32'd1);
        check("j_addr", 32'(imem_addr), 32'h01);
        check("j_wdata", imem_wdata, 32'h08000010);
        step();
        check("ij_we_done", 32'(imem_we), 32'd0);
        check("ij_count", 32'(count), 32'd2);
        check("ij_addr_next", 32'(imem_addr), 32'h02);

        // Illegal format: one-cycle fmt_err, nothing written
        do_reset();
        in_valid = 1'b1; fmt = 2'd3; opcode = 6'h3f; immediate = 16'hbeef;
        #1;
        check("ill_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("ill_err", 32'(fmt_err), 32'd1);
        check("ill_we", 32'(imem_we), 32'd0);
        check("ill_busy", 32'(busy), 32'd0);
        step();
        check("ill_err_clr", 32'(fmt_err), 32'd0);
        check("ill_we2", 32'(imem_we), 32'd0);
        check("ill_count", 32'(count), 32'd0);

        // Backpressure: fill 4 entries, 5th refused, then drain in order
        imem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_i(6'h08, 5'd1, 5'd2, 16'(k + 1));
            #1;
            check($sformatf("bp_ready_%0d", k), 32'(in_ready), 32'd1);
            step();
        end
        drive_i(6'h08, 5'd1, 5'd2, 16'h0099);
        #1;
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_head", imem_wdata, 32'h20220001);
        step();
        check("bp_hold_we", 32'(imem_we), 32'd1);
        check("bp_hold_addr", 32'(imem_addr), 32'h00);
        check("bp_hold_wdata", imem_wdata, 32'h20220001);
        in_valid = 1'b0;
        imem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain_we_%0d", k), 32'(imem_we), 32'd1);
            check($sformatf("drain_addr_%0d", k), 32'(imem_addr), 32'(k));
            check($sformatf("drain_wdata_%0d", k), imem_wdata, 32'h20220000 | 32'(k + 1));
            step();
        end
        check("drain_we_end", 32'(imem_we), 32'd0);
        check("drain_count", 32'(count), 32'd4);

        // Address wrap after load_start, plus ignored load_start while busy
        do_reset();
        load_start = 1'b1; start_addr = 8'hFF;
        in_valid = 1'b1; fmt = 2'd2; opcode = 6'h02; address = 26'h1;
        #1;
        check("ld_in_ready", 32'(in_ready), 32'd0);
        step();
        load_start = 1'b0;
        in_valid = 1'b0;
        check("ld_addr", 32'(imem_addr), 32'hFF);
        check("ld_no_push", 32'(busy), 32'd0);
        imem_ready = 1'b0;
        drive_j(6'h02, 26'h0000AAA);
        step();
        drive_j(6'h03, 26'h0000BBB);
        step();
        in_valid = 1'b0;
        load_start = 1'b1; start_addr = 8'h40;
        #1;
        check("ign_in_ready", 32'(in_ready), 32'd0);
        step();
        load_start = 1'b0;
        check("ign_addr", 32'(imem_addr), 32'hFF);
        imem_ready = 1'b1;
        #1;
        check("wrap_addr0", 32'(imem_addr), 32'hFF);
        check("wrap_wdata0", imem_wdata, 32'h08000AAA);
        step();
        check("wrap_addr1", 32'(imem_addr), 32'h00);
        check("wrap_wdata1", imem_wdata, 32'h0C000BBB);
        step();
        check("wrap_we_end", 32'(imem_we), 32'd0);
        check("wrap_count", 32'(count), 32'd2);
        check("wrap_addr_next", 32'(imem_addr), 32'h01);

        // Reset mid-drain with a coincident handshake and load_start
        imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_i(6'h08, 5'd3, 5'd4, 16'(k));
            step();
        end
        in_valid = 1'b0;
        check("md_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        imem_ready = 1'b1;
        load_start = 1'b1; start_addr = 8'h77;
        drive_i(6'h08, 5'd1, 5'd1, 16'h1234);
        step();
        reset = 1'b0;
        idle_inputs();
        check("md_busy_clr", 32'(busy), 32'd0);
        check("md_count", 32'(count), 32'd0);
        check("md_addr", 32'(imem_addr), 32'h00);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("md_no_we_%0d", k), 32'(imem_we), 32'd0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
